// File: rtl/cab_master_nb.sv
// CAB master bridge: turns one REG_DW-bit register access into a header beat plus
// REG_DW/CAB_DW data beats on the CAB bus, with a read-response timeout.
module cab_master_nb #(
    parameter int CAB_DW  = 16,
    parameter int REG_DW  = 32,
    parameter int AW      = 16,
    parameter int LAN_W   = 1,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              xxo_cab_mreq,
    output logic [CAB_DW-1:0] xxo_cab_mwdata,
    input  logic              cab_xxo_mreq_rdy,
    input  logic              cab_xxo_mdn,
    input  logic [CAB_DW-1:0] cab_xxo_mrdata,
    input  logic              xxi_cab_mreq,
    input  logic [LAN_W-1:0]  xxi_cab_mlan,
    input  logic [AW-1:0]     xxi_cab_maddr,
    input  logic [REG_DW-1:0] xxi_cab_mwdata,
    input  logic              xxi_cab_mwr,
    output logic              cab_xxi_mreq_rdy,
    output logic              cab_xxi_mdn,
    output logic              cab_xxi_merr,
    output logic [REG_DW-1:0] cab_xxi_mrdata
);

    localparam int NBEAT = REG_DW / CAB_DW;
    localparam int AFW   = CAB_DW - LAN_W - 1;
    localparam int BCW   = $clog2(NBEAT);
    localparam int TCW   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam bit TMO_EN = (TMO_CYC > 0);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEAT - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ADDR = 4'b0010,
        WDAT = 4'b0100,
        RDAT = 4'b1000
    } state_t;

    state_t state, state_nxt;

    logic [AFW-1:0]    addr_q;
    logic [LAN_W-1:0]  lan_q;
    logic              wr_q;
    logic [REG_DW-1:0] wdata_q;
    logic [REG_DW-1:0] rdata_q;
    logic [BCW-1:0]    beat_q;
    logic [TCW-1:0]    tmo_q;
    logic              rdy_q;
    logic              mdn_q;
    logic              merr_q;

    logic capture;
    logic hdr_done;
    logic beat_adv;
    logic rd_store;
    logic rd_done;
    logic rd_tmo;

    // Only maddr[AFW+1:2] is carried in the header; the rest is don't-care.
    logic unused_addr;
    assign unused_addr = ^xxi_cab_maddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        xxo_cab_mreq   = 1'b0;
        xxo_cab_mwdata = '0;
        capture        = 1'b0;
        hdr_done       = 1'b0;
        beat_adv       = 1'b0;
        rd_store       = 1'b0;
        rd_done        = 1'b0;
        rd_tmo         = 1'b0;
        case (state)
            IDLE: begin
                if (xxi_cab_mreq) begin
                    capture   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                xxo_cab_mreq   = 1'b1;
                xxo_cab_mwdata = {addr_q, lan_q, wr_q};
                if (cab_xxo_mreq_rdy) begin
                    hdr_done  = 1'b1;
                    state_nxt = wr_q ? WDAT : RDAT;
                end
            end
            WDAT: begin
                xxo_cab_mreq   = 1'b1;
                xxo_cab_mwdata = wdata_q[beat_q*CAB_DW +: CAB_DW];
                if (cab_xxo_mreq_rdy) begin
                    beat_adv = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RDAT: begin
                // A beat arriving on the terminal count takes priority over the timeout.
                if (cab_xxo_mdn) begin
                    rd_store = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        rd_done   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    rd_tmo    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            lan_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            rdy_q   <= 1'b1;
            mdn_q   <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            rdy_q  <= (state_nxt == IDLE);
            mdn_q  <= rd_done | rd_tmo;
            merr_q <= rd_tmo;
            if (capture) begin
                addr_q <= xxi_cab_maddr[AFW+1:2];
                lan_q  <= xxi_cab_mlan;
                wr_q   <= xxi_cab_mwr;
                if (xxi_cab_mwr) begin
                    wdata_q <= xxi_cab_mwdata;
                end else begin
                    rdata_q <= '0;
                end
            end
            if (hdr_done) begin
                beat_q <= '0;
                tmo_q  <= '0;
            end else if (beat_adv) begin
                beat_q <= beat_q + 1'b1;
            end else if (rd_store) begin
                rdata_q[beat_q*CAB_DW +: CAB_DW] <= cab_xxo_mrdata;
                beat_q <= beat_q + 1'b1;
                tmo_q  <= '0;
            end else if (state == RDAT) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign cab_xxi_mreq_rdy = rdy_q;
    assign cab_xxi_mdn      = mdn_q;
    assign cab_xxi_merr     = merr_q;
    assign cab_xxi_mrdata   = rdata_q;

endmodule

// File: tb/tb_cab_master_nb.sv
// Bench for cab_master_nb: one 16/32-bit instance with a short read timeout and
// one 8/32-bit instance with a 2-bit LAN select, checked against a transaction model.
module tb_cab_master_nb;

    localparam int TMO_A = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic        a_mreq_o;
    logic [15:0] a_wbeat;
    logic        a_cab_rdy, a_cab_dn;
    logic [15:0] a_cab_rd;
    logic        a_req;
    logic [0:0]  a_lan;
    logic [15:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_wr;
    logic        a_rdy, a_dn, a_err;
    logic [31:0] a_rdata;

    logic        b_mreq_o;
    logic [7:0]  b_wbeat;
    logic        b_cab_rdy, b_cab_dn;
    logic [7:0]  b_cab_rd;
    logic        b_req;
    logic [1:0]  b_lan;
    logic [15:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_wr;
    logic        b_rdy, b_dn, b_err;
    logic [31:0] b_rdata;

    cab_master_nb #(.CAB_DW(16), .REG_DW(32), .AW(16), .LAN_W(1), .TMO_CYC(TMO_A)) u_a (
        .clk(clk), .rst_n(rst_n),
        .xxo_cab_mreq(a_mreq_o), .xxo_cab_mwdata(a_wbeat),
        .cab_xxo_mreq_rdy(a_cab_rdy), .cab_xxo_mdn(a_cab_dn), .cab_xxo_mrdata(a_cab_rd),
        .xxi_cab_mreq(a_req), .xxi_cab_mlan(a_lan), .xxi_cab_maddr(a_addr),
        .xxi_cab_mwdata(a_wdata), .xxi_cab_mwr(a_wr),
        .cab_xxi_mreq_rdy(a_rdy), .cab_xxi_mdn(a_dn), .cab_xxi_merr(a_err),
        .cab_xxi_mrdata(a_rdata)
    );

    cab_master_nb #(.CAB_DW(8), .REG_DW(32), .AW(16), .LAN_W(2), .TMO_CYC(255)) u_b (
        .clk(clk), .rst_n(rst_n),
        .xxo_cab_mreq(b_mreq_o), .xxo_cab_mwdata(b_wbeat),
        .cab_xxo_mreq_rdy(b_cab_rdy), .cab_xxo_mdn(b_cab_dn), .cab_xxo_mrdata(b_cab_rd),
        .xxi_cab_mreq(b_req), .xxi_cab_mlan(b_lan), .xxi_cab_maddr(b_addr),
        .xxi_cab_mwdata(b_wdata), .xxi_cab_mwr(b_wr),
        .cab_xxi_mreq_rdy(b_rdy), .cab_xxi_mdn(b_dn), .cab_xxi_merr(b_err),
        .cab_xxi_mrdata(b_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Header = word address (addr/4, truncated to the field) above lan above wr.
    function automatic logic [15:0] hdr_a(input logic [15:0] addr, input logic [0:0] lan, input logic wr);
        int h;
        h = ((int'(addr) / 4) % 16384) * 4 + int'(lan) * 2 + int'(wr);
        return 16'(h);
    endfunction

    function automatic logic [7:0] hdr_b(input logic [15:0] addr, input logic [1:0] lan, input logic wr);
        int h;
        h = ((int'(addr) / 4) % 32) * 8 + int'(lan) * 2 + int'(wr);
        return 8'(h);
    endfunction

    // Write on instance A; st* = cycles mreq_rdy is held low before each beat is accepted.
    task automatic wr_a(input logic [15:0] addr, input logic [0:0] lan, input logic [31:0] data,
                        input int st0, input int st1, input int st2, input bit hold);
        int stl[3];
        logic [15:0] expw;
        stl[0] = st0; stl[1] = st1; stl[2] = st2;
        chk("a_wr_accept_rdy", a_rdy, 1);
        a_req = 1'b1; a_wr = 1'b1; a_addr = addr; a_lan = lan; a_wdata = data; a_cab_rdy = 1'b0;
        tick();
        if (hold) begin
            a_addr = ~addr; a_wdata = ~data; a_wr = 1'b0;
        end else begin
            a_req = 1'b0;
        end
        chk("a_wr_busy", a_rdy, 0);
        chk("a_wr_no_dn", a_dn, 0);
        chk("a_wr_no_err", a_err, 0);
        for (int b = 0; b < 3; b++) begin
            expw = (b == 0) ? hdr_a(addr, lan, 1'b1) : 16'(data >> (16 * (b - 1)));
            for (int s = 0; s < stl[b]; s++) begin
                a_cab_rdy = 1'b0;
                chk("a_wr_hold_vld", a_mreq_o, 1);
                chk("a_wr_hold_beat", a_wbeat, expw);
                tick();
            end
            a_cab_rdy = 1'b1;
            chk("a_wr_vld", a_mreq_o, 1);
            chk("a_wr_beat", a_wbeat, expw);
            chk("a_wr_dn_low", a_dn, 0);
            tick();
        end
        a_cab_rdy = 1'b0;
        a_req = 1'b0;
        chk("a_wr_done_rdy", a_rdy, 1);
        chk("a_wr_done_vld", a_mreq_o, 0);
        chk("a_wr_done_dn", a_dn, 0);
    endtask

    // Read on instance A; g* idle cycles precede each returned beat, and a run of
    // TMO_A idle cycles aborts the read with an error.
    task automatic rd_a(input logic [15:0] addr, input logic [0:0] lan, input int g0, input int g1,
                        input logic [15:0] b0, input logic [15:0] b1, input bit stray);
        int gaps[2];
        logic [15:0] bt[2];
        logic [31:0] exp_rd;
        bit tmo;
        gaps[0] = g0; gaps[1] = g1; bt[0] = b0; bt[1] = b1;
        exp_rd = '0;
        tmo = 1'b0;
        chk("a_rd_accept_rdy", a_rdy, 1);
        a_req = 1'b1; a_wr = 1'b0; a_addr = addr; a_lan = lan; a_wdata = $urandom;
        tick();
        a_req = 1'b0;
        chk("a_rd_hdr", a_wbeat, hdr_a(addr, lan, 1'b0));
        chk("a_rd_hdr_vld", a_mreq_o, 1);
        chk("a_rd_busy", a_rdy, 0);
        a_cab_rdy = 1'b1;
        if (stray) begin
            a_cab_dn = 1'b1; a_cab_rd = 16'hFFFF;
        end
        tick();
        a_cab_dn = 1'b0;
        for (int i = 0; i < 2 && !tmo; i++) begin
            for (int c = 0; c < gaps[i] && !tmo; c++) begin
                chk("a_rdat_vld", a_mreq_o, 0);
                chk("a_rdat_wbeat", a_wbeat, 0);
                chk("a_rdat_dn", a_dn, 0);
                a_cab_rdy = 1'($urandom);
                tick();
                if (c + 1 >= TMO_A) tmo = 1'b1;
            end
            if (!tmo) begin
                a_cab_dn = 1'b1; a_cab_rd = bt[i];
                exp_rd = exp_rd + (32'(bt[i]) << (16 * i));
                tick();
                a_cab_dn = 1'b0;
            end
        end
        a_cab_rdy = 1'b0;
        chk("a_rd_dn", a_dn, 1);
        chk("a_rd_err", a_err, 32'(tmo));
        chk("a_rd_rdy", a_rdy, 1);
        chk("a_rd_data", a_rdata, exp_rd);
    endtask

    task automatic idle_a();
        tick();
        chk("a_dn_clr", a_dn, 0);
        chk("a_err_clr", a_err, 0);
        chk("a_rdy_idle", a_rdy, 1);
    endtask

    task automatic wr_b(input logic [15:0] addr, input logic [1:0] lan, input logic [31:0] data,
                        input int st[5]);
        logic [7:0] expw;
        chk("b_wr_accept_rdy", b_rdy, 1);
        b_req = 1'b1; b_wr = 1'b1; b_addr = addr; b_lan = lan; b_wdata = data; b_cab_rdy = 1'b0;
        tick();
        b_req = 1'b0;
        chk("b_wr_busy", b_rdy, 0);
        for (int b = 0; b < 5; b++) begin
            expw = (b == 0) ? hdr_b(addr, lan, 1'b1) : 8'(data >> (8 * (b - 1)));
            for (int s = 0; s < st[b]; s++) begin
                b_cab_rdy = 1'b0;
                chk("b_wr_hold_vld", b_mreq_o, 1);
                chk("b_wr_hold_beat", b_wbeat, expw);
                tick();
            end
            b_cab_rdy = 1'b1;
            chk("b_wr_vld", b_mreq_o, 1);
            chk("b_wr_beat", b_wbeat, expw);
            tick();
        end
        b_cab_rdy = 1'b0;
        chk("b_wr_done_rdy", b_rdy, 1);
        chk("b_wr_done_vld", b_mreq_o, 0);
        chk("b_wr_done_dn", b_dn, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_cab_rdy = 0; a_cab_dn = 0; a_cab_rd = '0; a_req = 0; a_lan = '0; a_addr = '0; a_wdata = '0; a_wr = 0;
        b_cab_rdy = 0; b_cab_dn = 0; b_cab_rd = '0; b_req = 0; b_lan = '0; b_addr = '0; b_wdata = '0; b_wr = 0;
        #12;
        chk("rst_a_rdy", a_rdy, 1);
        chk("rst_a_dn", a_dn, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_vld", a_mreq_o, 0);
        chk("rst_a_wbeat", a_wbeat, 0);
        chk("rst_b_rdy", b_rdy, 1);
        chk("rst_b_vld", b_mreq_o, 0);
        rst_n = 1'b1;
        tick();

        wr_a(16'h0104, 1'b1, 32'h12345678, 0, 0, 0, 1'b0);
        idle_a();
        rd_a(16'h0008, 1'b0, 0, 2, 16'hBEEF, 16'hDEAD, 1'b1);
        idle_a();
        rd_a(16'h0040, 1'b1, 0, 20, 16'h1111, 16'h2222, 1'b0);
        idle_a();
        rd_a(16'h0044, 1'b0, 3, 3, 16'hCAFE, 16'hF00D, 1'b0);
        idle_a();

        wr_b(16'h0014, 2'd2, 32'hA1B2C3D4, '{0, 0, 3, 0, 0});
        tick();
        chk("b_idle_dn", b_dn, 0);

        rd_a(16'h0010, 1'b1, 1, 0, 16'h0A0B, 16'h0C0D, 1'b0);
        wr_a(16'h0020, 1'b0, 32'h55AA33CC, 1, 0, 2, 1'b1);
        idle_a();

        // Reset in the middle of a read, then late CAB beats must be ignored.
        a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0030; a_lan = 1'b1;
        tick();
        a_req = 1'b0; a_cab_rdy = 1'b1;
        tick();
        a_cab_rdy = 1'b0; a_cab_dn = 1'b1; a_cab_rd = 16'h5A5A;
        tick();
        a_cab_dn = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", a_rdy, 1);
        chk("mid_rst_dn", a_dn, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_rdata", a_rdata, 0);
        chk("mid_rst_vld", a_mreq_o, 0);
        chk("mid_rst_wbeat", a_wbeat, 0);
        tick();
        rst_n = 1'b1;
        a_cab_dn = 1'b1; a_cab_rd = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_dn", a_dn, 0);
            chk("post_rst_rdata", a_rdata, 0);
            chk("post_rst_rdy", a_rdy, 1);
        end
        a_cab_dn = 1'b0;

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_a(16'($urandom) & 16'hFFFC, 1'($urandom), $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
            end else begin
                rd_a(16'($urandom) & 16'hFFFC, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                     16'($urandom), 16'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 1) == 1) idle_a();
        end
        for (int n = 0; n < 4; n++) begin
            wr_b(16'($urandom) & 16'hFFFC, 2'($urandom), $urandom,
                 '{$urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
